uart_rx_frame_deser: RTL and testbench

//  Clocked, parametrised successor to the UART RX deserializer. Consumes one

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_frame_deser_if.sv | 25 ++
 rtl/uart_parity_calc.sv | 12 +
 rtl/uart_rx_frame_deser.sv | 134 +++++++++++++
 tb/tb_uart_rx_frame_deser.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the RX frame deserializer and the parity helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_frame_deser_if.sv
// Bundle between the RX sampler/top level and the frame deserializer.
interface uart_rx_frame_deser_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sample_vld;
    logic                  sampled_bit;
    logic                  par_en;
    logic                  par_typ;
    logic                  frame_abort;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_vld;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output sample_vld, sampled_bit, par_en, par_typ, frame_abort,
        input  p_data, data_vld, par_err, stp_err, busy
    );

    modport slave (
        input  sample_vld, sampled_bit, par_en, par_typ, frame_abort,
        output p_data, data_vld, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_parity_calc.sv
// Expected parity bit for a data word; shared by the UART TX and RX paths.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_par_exp
);
    assign o_par_exp = (^i_data) ^ (i_par_typ == PAR_ODD);
endmodule

// File: rtl/uart_rx_frame_deser.sv
// UART RX frame deserializer: tracks start/data/parity/stop, assembles LSB-first data,
// checks parity and stop bits and strobes a registered result for one clock.
module uart_rx_frame_deser #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_frame_deser_if.slave  bus
);
    import uart_pkg::*;

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);

    rx_state_e             r_state;
    rx_state_e             w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  r_stop_cnt;
    logic                  r_cfg_par_en;
    logic                  r_cfg_par_typ;
    logic                  r_par_bad;
    logic                  r_stp_bad;
    logic                  r_data_vld;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic                  r_busy;

    logic                  w_last_data;
    logic                  w_last_stop;
    logic                  w_par_exp;
    logic                  w_stp_bad_fin;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (r_shreg),
        .i_par_typ (r_cfg_par_typ),
        .o_par_exp (w_par_exp)
    );

    assign w_last_data   = (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
    assign w_last_stop   = (STOP_BITS == 1) ? 1'b1 : r_stop_cnt;
    assign w_stp_bad_fin = r_stp_bad | ~bus.sampled_bit;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.frame_abort) begin
            w_state_nxt = IDLE;
        end else if (bus.sample_vld) begin
            case (r_state)
                IDLE:    if (!bus.sampled_bit) w_state_nxt = DATA;
                DATA:    if (w_last_data) w_state_nxt = r_cfg_par_en ? PARITY : STOP;
                PARITY:  w_state_nxt = STOP;
                STOP:    if (w_last_stop) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_shreg       <= '0;
            r_p_data      <= '0;
            r_bit_cnt     <= '0;
            r_stop_cnt    <= 1'b0;
            r_cfg_par_en  <= 1'b0;
            r_cfg_par_typ <= 1'b0;
            r_par_bad     <= 1'b0;
            r_stp_bad     <= 1'b0;
            r_data_vld    <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_data_vld <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
            if (bus.frame_abort) begin
                r_busy     <= 1'b0;
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
            end else if (bus.sample_vld) begin
                case (r_state)
                    IDLE: begin
                        if (!bus.sampled_bit) begin
                            r_cfg_par_en  <= bus.par_en;
                            r_cfg_par_typ <= bus.par_typ;
                            r_bit_cnt     <= '0;
                            r_stop_cnt    <= 1'b0;
                            r_par_bad     <= 1'b0;
                            r_stp_bad     <= 1'b0;
                            r_busy        <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_shreg <= {bus.sampled_bit, r_shreg[DATA_WIDTH-1:1]};
                        // Counter parks on the last index so it never wraps inside a frame.
                        if (!w_last_data) r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                    end
                    PARITY: begin
                        r_par_bad <= (bus.sampled_bit != w_par_exp);
                    end
                    STOP: begin
                        r_stp_bad <= w_stp_bad_fin;
                        if (w_last_stop) begin
                            r_busy <= 1'b0;
                            if (!r_par_bad && !w_stp_bad_fin) begin
                                r_p_data   <= r_shreg;
                                r_data_vld <= 1'b1;
                            end else begin
                                r_par_err <= r_par_bad;
                                r_stp_err <= w_stp_bad_fin;
                            end
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                    default: r_busy <= 1'b0;
                endcase
            end
        end
    end

    assign bus.p_data   = r_p_data;
    assign bus.data_vld = r_data_vld;
    assign bus.par_err  = r_par_err;
    assign bus.stp_err  = r_stp_err;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_deser.sv
// Directed bench for uart_rx_frame_deser: an 8-bit/1-stop instance and a 7-bit/2-stop instance.
module tb_uart_rx_frame_deser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cnt_a = 0;
    int   cnt_b = 0;

    always #5 clk = ~clk;

    uart_rx_frame_deser_if #(.DATA_WIDTH(8)) ifa ();
    uart_rx_frame_deser_if #(.DATA_WIDTH(7)) ifb ();

    uart_rx_frame_deser #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    uart_rx_frame_deser #(.DATA_WIDTH(7), .STOP_BITS(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // Strobe counters catch extra or missing data_vld pulses.
    always @(negedge clk) begin
        if (ifa.data_vld === 1'b1) cnt_a++;
        if (ifb.data_vld === 1'b1) cnt_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_a(input logic [7:0] d, input logic pen, input logic pbit,
                           input logic sbit, input logic flip_cfg);
        ifa.sample_vld  = 1'b1;
        ifa.sampled_bit = 1'b0;
        tick();
        if (flip_cfg) begin
            ifa.par_en  = ~ifa.par_en;
            ifa.par_typ = ~ifa.par_typ;
        end
        for (int i = 0; i < 8; i++) begin
            ifa.sampled_bit = d[i];
            tick();
        end
        if (pen) begin
            ifa.sampled_bit = pbit;
            tick();
        end
        ifa.sampled_bit = sbit;
        tick();
        ifa.sample_vld  = 1'b0;
        ifa.sampled_bit = 1'b1;
    endtask

    task automatic frame_b(input logic [6:0] d, input logic s1, input logic s2);
        ifb.sample_vld  = 1'b1;
        ifb.sampled_bit = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            ifb.sampled_bit = d[i];
            tick();
        end
        ifb.sampled_bit = s1;
        tick();
        ifb.sampled_bit = s2;
        tick();
        ifb.sample_vld  = 1'b0;
        ifb.sampled_bit = 1'b1;
    endtask

    initial begin
        ifa.sample_vld = 1'b0; ifa.sampled_bit = 1'b1; ifa.par_en = 1'b0;
        ifa.par_typ = 1'b0; ifa.frame_abort = 1'b0;
        ifb.sample_vld = 1'b0; ifb.sampled_bit = 1'b1; ifb.par_en = 1'b0;
        ifb.par_typ = 1'b0; ifb.frame_abort = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_pdata", 32'(ifa.p_data), 32'h00);
        chk("rst_vld", 32'(ifa.data_vld), 32'h0);
        chk("rst_busy", 32'(ifa.busy), 32'h0);
        chk("rst_errs", 32'({ifa.par_err, ifa.stp_err}), 32'h0);
        rst = 1'b0;
        tick();

        // 1: 8N1, 0xA5
        frame_a(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_vld", 32'(ifa.data_vld), 32'h1);
        chk("t1_pdata", 32'(ifa.p_data), 32'hA5);
        chk("t1_errs", 32'({ifa.par_err, ifa.stp_err}), 32'h0);
        chk("t1_busy", 32'(ifa.busy), 32'h0);
        tick();
        chk("t1_vld_width", 32'(ifa.data_vld), 32'h0);

        // 2: 8E1, 0x03 parity 0; config flipped mid-frame must be ignored
        ifa.par_en = 1'b1; ifa.par_typ = 1'b0;
        frame_a(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t2_vld", 32'(ifa.data_vld), 32'h1);
        chk("t2_pdata", 32'(ifa.p_data), 32'h03);
        chk("t2_parerr", 32'(ifa.par_err), 32'h0);
        tick();

        // 3: 8O1, 0x03 parity 0 -> parity error
        ifa.par_en = 1'b1; ifa.par_typ = 1'b1;
        frame_a(8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t3_parerr", 32'(ifa.par_err), 32'h1);
        chk("t3_stperr", 32'(ifa.stp_err), 32'h0);
        chk("t3_vld", 32'(ifa.data_vld), 32'h0);
        chk("t3_pdata", 32'(ifa.p_data), 32'h03);
        tick();
        chk("t3_parerr_width", 32'(ifa.par_err), 32'h0);

        // 4: 8N1, 0x5A stop 0 -> stop error
        ifa.par_en = 1'b0; ifa.par_typ = 1'b0;
        frame_a(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_stperr", 32'(ifa.stp_err), 32'h1);
        chk("t4_parerr", 32'(ifa.par_err), 32'h0);
        chk("t4_vld", 32'(ifa.data_vld), 32'h0);
        chk("t4_busy", 32'(ifa.busy), 32'h0);
        chk("t4_pdata", 32'(ifa.p_data), 32'h03);
        tick();

        // 5: abort after four data bits (abort wins over a low sample), then 0xFF
        ifa.sample_vld = 1'b1; ifa.sampled_bit = 1'b0;
        tick();
        chk("t5_busy_start", 32'(ifa.busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            ifa.sampled_bit = 1'b1;
            tick();
        end
        ifa.frame_abort = 1'b1; ifa.sampled_bit = 1'b0;
        tick();
        ifa.frame_abort = 1'b0; ifa.sample_vld = 1'b0; ifa.sampled_bit = 1'b1;
        chk("t5_busy_abort", 32'(ifa.busy), 32'h0);
        chk("t5_abort_quiet", 32'({ifa.data_vld, ifa.par_err, ifa.stp_err}), 32'h0);
        chk("t5_abort_pdata", 32'(ifa.p_data), 32'h03);
        tick();
        frame_a(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_vld", 32'(ifa.data_vld), 32'h1);
        chk("t5_pdata", 32'(ifa.p_data), 32'hFF);
        tick();
        chk("t5_vld_count", 32'(cnt_a), 32'd3);

        // 6: back-to-back 0x11 then 0x22
        frame_a(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_vld1", 32'(ifa.data_vld), 32'h1);
        chk("t6_pdata1", 32'(ifa.p_data), 32'h11);
        frame_a(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_vld2", 32'(ifa.data_vld), 32'h1);
        chk("t6_pdata2", 32'(ifa.p_data), 32'h22);
        tick();
        chk("t6_vld_count", 32'(cnt_a), 32'd5);

        // 6b: 7-bit, two stop bits
        frame_b(7'h55, 1'b1, 1'b1);
        chk("t6b_vld", 32'(ifb.data_vld), 32'h1);
        chk("t6b_pdata", 32'(ifb.p_data), 32'h55);
        tick();
        frame_b(7'h2A, 1'b1, 1'b0);
        chk("t6b_stperr", 32'(ifb.stp_err), 32'h1);
        chk("t6b_pdata_hold", 32'(ifb.p_data), 32'h55);
        tick();
        chk("t6b_vld_count", 32'(cnt_b), 32'd1);

        // Reset mid-frame, then a clean frame
        ifa.sample_vld = 1'b1; ifa.sampled_bit = 1'b0;
        tick();
        ifa.sampled_bit = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; ifa.sample_vld = 1'b0;
        chk("rst_mid_busy", 32'(ifa.busy), 32'h0);
        chk("rst_mid_pdata", 32'(ifa.p_data), 32'h00);
        tick();
        frame_a(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_mid_vld", 32'(ifa.data_vld), 32'h1);
        chk("rst_mid_pdata2", 32'(ifa.p_data), 32'h3C);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
